// File: rtl/dcache_data_array_pipe.sv
// N-way, byte-maskable, single-ported D-cache data array with a valid/ready request
// handshake and a one-entry registered read-response stage that honours backpressure.
module dcache_data_array_pipe #(
    parameter int NWAYS       = 4,
    parameter int WORD_BITS   = 32,
    parameter int ADDR_BITS   = 12,
    parameter int OFFSET_BITS = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_req_valid,
    output logic                       io_req_ready,
    input  logic [ADDR_BITS-1:0]       io_req_bits_addr,
    input  logic                       io_req_bits_write,
    input  logic [WORD_BITS-1:0]       io_req_bits_wdata,
    input  logic [WORD_BITS/8-1:0]     io_req_bits_eccMask,
    input  logic [NWAYS-1:0]           io_req_bits_way_en,
    output logic                       io_resp_valid,
    input  logic                       io_resp_ready,
    output logic [NWAYS*WORD_BITS-1:0] io_resp_bits_data
);

    localparam int NBYTES   = WORD_BITS / 8;
    localparam int ROW_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int ROWS     = 2 ** ROW_BITS;

    logic [WORD_BITS-1:0]       r_mem [ROWS][NWAYS];
    logic                       r_resp_valid;
    logic [NWAYS*WORD_BITS-1:0] r_resp_data;

    logic                       w_fire;
    logic                       w_rd_fire;
    logic                       w_wr_fire;
    logic [ROW_BITS-1:0]        w_row;
    logic [OFFSET_BITS-1:0]     w_unused_offset;
    logic [NWAYS*WORD_BITS-1:0] w_rd_data;

    // A held response blocks new requests until the consumer takes it.
    assign io_req_ready    = ~r_resp_valid | io_resp_ready;
    assign w_fire          = io_req_valid & io_req_ready & ~reset;
    assign w_rd_fire       = w_fire & ~io_req_bits_write;
    assign w_wr_fire       = w_fire & io_req_bits_write;
    assign w_row           = io_req_bits_addr[ADDR_BITS-1:OFFSET_BITS];
    assign w_unused_offset = io_req_bits_addr[OFFSET_BITS-1:0];

    assign io_resp_valid     = r_resp_valid;
    assign io_resp_bits_data = r_resp_data;

    // Gather all ways of the addressed row for the response register.
    always_comb begin
        w_rd_data = '0;
        for (int w = 0; w < NWAYS; w++) begin
            w_rd_data[w*WORD_BITS +: WORD_BITS] = r_mem[w_row][w];
        end
    end

    // Row memory: byte lane b of way w written only when both its mask bit and way enable are set.
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            for (int w = 0; w < NWAYS; w++) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (io_req_bits_eccMask[b] && io_req_bits_way_en[w]) begin
                        r_mem[w_row][w][b*8 +: 8] <= io_req_bits_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Response stage: load on a read, drop valid when drained; data retained after drain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else if (w_rd_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_rd_data;
        end else if (io_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

endmodule
